core_mem_arbiter: RTL

- Shares one single-port synchronous SRAM (1-cycle read latency) between three requesters: core instruction fetch (IF), core data access (M stage), and the host/loader port.
- Sits between core and memory macro. Returns per-requester grant and read-valid pulses; core stalls on missing grant.
- Host can lock out the core for program load. A saturating conflict counter supports performance debug.

---
 rtl/core_mem_arbiter_if.sv | 72 +++++++
 rtl/core_mem_arbiter.sv | 108 ++++++++++
 2 files changed

// File: rtl/core_mem_arbiter_if.sv
// Bundle of every requester, response and memory-macro signal around the
// shared single-port SRAM, seen from the arbiter (slave) or the environment (master).
interface core_mem_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
);
   // Handshake: a requester raises req with address/data and holds them until
   // gnt is seen in the same cycle; gnt completes the transfer. A granted read
   // returns exactly one rvalid pulse with rdata on the following cycle.
   logic                  i_if_req;
   logic [ADDR_WIDTH-1:0] i_if_addr;
   logic                  o_if_gnt;
   logic                  o_if_rvalid;
   logic [DATA_WIDTH-1:0] o_if_rdata;

   logic                  i_d_req;
   logic                  i_d_we;
   logic [ADDR_WIDTH-1:0] i_d_addr;
   logic [DATA_WIDTH-1:0] i_d_wdata;
   logic                  o_d_gnt;
   logic                  o_d_rvalid;
   logic [DATA_WIDTH-1:0] o_d_rdata;

   logic                  i_h_req;
   logic                  i_h_we;
   logic [ADDR_WIDTH-1:0] i_h_addr;
   logic [DATA_WIDTH-1:0] i_h_wdata;
   logic                  o_h_gnt;
   logic                  o_h_rvalid;
   logic [DATA_WIDTH-1:0] o_h_rdata;

   logic                  i_h_lock;
   logic                  o_locked;

   logic                  o_mem_en;
   logic                  o_mem_we;
   logic [ADDR_WIDTH-1:0] o_mem_addr;
   logic [DATA_WIDTH-1:0] o_mem_wdata;
   logic [DATA_WIDTH-1:0] i_mem_rdata;

   logic [CNT_WIDTH-1:0]  o_conflict_cnt;
   logic [1:0]            o_state_dbg;

   modport slave (
      input  i_if_req, i_if_addr,
      output o_if_gnt, o_if_rvalid, o_if_rdata,
      input  i_d_req, i_d_we, i_d_addr, i_d_wdata,
      output o_d_gnt, o_d_rvalid, o_d_rdata,
      input  i_h_req, i_h_we, i_h_addr, i_h_wdata,
      output o_h_gnt, o_h_rvalid, o_h_rdata,
      input  i_h_lock,
      output o_locked,
      output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
      input  i_mem_rdata,
      output o_conflict_cnt, o_state_dbg
   );

   modport master (
      output i_if_req, i_if_addr,
      input  o_if_gnt, o_if_rvalid, o_if_rdata,
      output i_d_req, i_d_we, i_d_addr, i_d_wdata,
      input  o_d_gnt, o_d_rvalid, o_d_rdata,
      output i_h_req, i_h_we, i_h_addr, i_h_wdata,
      input  o_h_gnt, o_h_rvalid, o_h_rdata,
      output i_h_lock,
      input  o_locked,
      input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
      output i_mem_rdata,
      input  o_conflict_cnt, o_state_dbg
   );
endinterface

// File: rtl/core_mem_arbiter.sv
// Three-way arbiter (fetch, data, host) in front of a 1-cycle-latency SRAM,
// with host lock-out sequencing and a saturating fetch/data conflict counter.
module core_mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input logic                 clk,
   input logic                 rst,
   core_mem_arbiter_if.slave   bus
);
   typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_LOCKED = 2'd2} state_t;
   typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_D = 2'd2, OWN_H = 2'd3} owner_t;

   state_t               state_q;
   owner_t               owner_q;
   logic                 rr_q;      // 0: fetch favoured, 1: data favoured
   logic                 locked_q;
   logic [CNT_WIDTH-1:0] cnt_q;

   logic core_ok, if_gnt, d_gnt, h_gnt;

   // Grants are gated by reset so nothing leaks out while rst is low.
   always_comb begin
      core_ok = (state_q == ST_RUN) || ((state_q == ST_LOCKED) && !bus.i_h_lock);
      h_gnt   = rst && bus.i_h_req;
      if_gnt  = rst && core_ok && !bus.i_h_req && bus.i_if_req && (!bus.i_d_req || !rr_q);
      d_gnt   = rst && core_ok && !bus.i_h_req && bus.i_d_req && (!bus.i_if_req || rr_q);

      bus.o_mem_en    = h_gnt || if_gnt || d_gnt;
      bus.o_mem_we    = 1'b0;
      bus.o_mem_addr  = '0;
      bus.o_mem_wdata = '0;
      if (h_gnt) begin
         bus.o_mem_we    = bus.i_h_we;
         bus.o_mem_addr  = bus.i_h_addr;
         bus.o_mem_wdata = bus.i_h_wdata;
      end else if (if_gnt) begin
         bus.o_mem_addr  = bus.i_if_addr;
      end else if (d_gnt) begin
         bus.o_mem_we    = bus.i_d_we;
         bus.o_mem_addr  = bus.i_d_addr;
         bus.o_mem_wdata = bus.i_d_wdata;
      end
   end

   assign bus.o_if_gnt = if_gnt;
   assign bus.o_d_gnt  = d_gnt;
   assign bus.o_h_gnt  = h_gnt;

   assign bus.o_if_rvalid = (owner_q == OWN_IF);
   assign bus.o_d_rvalid  = (owner_q == OWN_D);
   assign bus.o_h_rvalid  = (owner_q == OWN_H);
   assign bus.o_if_rdata  = (owner_q == OWN_IF) ? bus.i_mem_rdata : '0;
   assign bus.o_d_rdata   = (owner_q == OWN_D)  ? bus.i_mem_rdata : '0;
   assign bus.o_h_rdata   = (owner_q == OWN_H)  ? bus.i_mem_rdata : '0;

   assign bus.o_locked       = locked_q;
   assign bus.o_conflict_cnt = cnt_q;
   assign bus.o_state_dbg    = state_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_RUN;
         owner_q  <= OWN_NONE;
         rr_q     <= 1'b0;
         locked_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         if (h_gnt && !bus.i_h_we)      owner_q <= OWN_H;
         else if (if_gnt)               owner_q <= OWN_IF;
         else if (d_gnt && !bus.i_d_we) owner_q <= OWN_D;
         else                           owner_q <= OWN_NONE;

         if (if_gnt)     rr_q <= 1'b1;
         else if (d_gnt) rr_q <= 1'b0;

         if ((state_q == ST_RUN) && bus.i_if_req && bus.i_d_req && !bus.i_h_req
             && (cnt_q != {CNT_WIDTH{1'b1}}))
            cnt_q <= cnt_q + CNT_WIDTH'(1);

         // A read granted in RUN returns during DRAIN, so DRAIN always lasts one cycle.
         case (state_q)
            ST_RUN: begin
               if (bus.i_h_lock) state_q <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (bus.i_h_lock) begin
                  state_q  <= ST_LOCKED;
                  locked_q <= 1'b1;
               end else begin
                  state_q  <= ST_RUN;
               end
            end
            ST_LOCKED: begin
               if (!bus.i_h_lock) begin
                  state_q  <= ST_RUN;
                  locked_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= ST_RUN;
               locked_q <= 1'b0;
            end
         endcase
      end
   end
endmodule
